// File: rtl/double_pkg.sv
// ---------------------------------------------------------------------------
// double_pkg
// Shared types and constants for the double-precision divider stream slice.
//   double_t      : raw IEEE-754 binary64 bit pattern
//   DOUBLE_NAN    : canonical quiet NaN
//   DOUBLE_ZERO   : positive zero
//   credit_width  : bits needed to count 0..depth inclusive
// ---------------------------------------------------------------------------
package double_pkg;

    typedef logic [63:0] double_t;

    localparam double_t DOUBLE_NAN  = 64'h7FF8000000000000;
    localparam double_t DOUBLE_ZERO = 64'h0;

    function automatic int unsigned credit_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/result_fifo.sv
// ---------------------------------------------------------------------------
// result_fifo
// Synchronous DEPTH x 64 FIFO holding quotients until the consumer takes them.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push       : write push_data at the tail this edge
//   push_data  : quotient to store
//   pop        : consumer takes the head this edge (ignored when empty)
//   data       : head entry, read straight from storage
//   valid      : FIFO non-empty
//   count      : current occupancy, 0..DEPTH
// Push and pop on the same edge are allowed at any occupancy; there is no
// bypass, so a value pushed into an empty FIFO shows up one cycle later.
// ---------------------------------------------------------------------------
module result_fifo
    import double_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push,
    input  double_t                          push_data,
    input  logic                             pop,
    output double_t                          data,
    output logic                             valid,
    output logic [credit_width(DEPTH)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    double_t         mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_pop;

    assign valid  = (count != '0);
    assign do_pop = pop && valid;
    assign data   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/double_div_stream.sv
// ---------------------------------------------------------------------------
// double_div_stream
// Valid/ready wrapper around a free-running fixed-latency double divider.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_a, in_b        : dividend / divisor, accepted on in_valid && in_ready
//   in_valid,in_ready : input handshake
//   div_a, div_b      : registered operands driven into the divider core
//   div_z             : quotient from the core, LATENCY cycles after div_a/b
//   out_z, out_valid  : FIFO head and non-empty flag
//   out_ready         : consumer pops on out_valid && out_ready
// A one-bit tag rides a shift register alongside the core so only quotients
// belonging to accepted pairs are captured. Credits (in-flight + stored)
// are capped at DEPTH, so every tagged quotient always has a FIFO slot even
// though the core itself cannot be stalled.
// ---------------------------------------------------------------------------
module double_div_stream
    import double_pkg::*;
#(
    parameter int unsigned LATENCY = 32,
    parameter int unsigned DEPTH   = 8
) (
    input  logic    clk,
    input  logic    rst_n,
    input  double_t in_a,
    input  double_t in_b,
    input  logic    in_valid,
    output logic    in_ready,
    output double_t div_a,
    output double_t div_b,
    input  double_t div_z,
    output double_t out_z,
    output logic    out_valid,
    input  logic    out_ready
);

    localparam int unsigned CW = credit_width(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [LATENCY:0] tag;
    logic [CW-1:0]    inflight;
    logic [CW-1:0]    fifo_count;
    logic [CW:0]      credit_sum;
    logic             accept;
    logic             push;
    logic             pop;

    // Depends only on registered counters, never on in_valid.
    assign credit_sum = {1'b0, inflight} + {1'b0, fifo_count};
    assign in_ready   = rst_n && (credit_sum < DEPTH_C);
    assign accept     = in_valid && in_ready;
    assign push       = tag[LATENCY];
    assign pop        = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_a    <= '0;
            div_b    <= '0;
            tag      <= '0;
            inflight <= '0;
        end else begin
            if (accept) begin
                div_a <= in_a;
                div_b <= in_b;
            end
            tag <= {tag[LATENCY-1:0], accept};
            if (accept && !push) begin
                inflight <= inflight + 1'b1;
            end else if (!accept && push) begin
                inflight <= inflight - 1'b1;
            end
        end
    end

    result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (div_z),
        .pop       (pop),
        .data      (out_z),
        .valid     (out_valid),
        .count     (fifo_count)
    );

endmodule

// File: doc/double_div_stream.md
# double_div_stream

Valid/ready stream adapter for the free-running, fixed-latency `double_div` core. It accepts IEEE-754 double operand pairs under a valid/ready handshake and drives them into the core. It tags each operand pair through a shift register matching the core's pipeline. It collects each tagged quotient into an output FIFO that can be back-pressured. Credit accounting guarantees that no result leaving the non-stallable core is ever dropped. It sits between a producer of operand pairs and a consumer of quotients, and takes the role the stimulus-driving and capture harness plays around the core in simulation.

## Interface
- `LATENCY`, 32: cycles from operands on `div_a`/`div_b` to the matching quotient on `div_z`. Must equal the attached core's latency; ≥1.
- `DEPTH`, 8: result FIFO entries; power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_a` in 64: dividend (double).
- `in_b` in 64: divisor (double).
- `in_valid` in 1: operand pair present.
- `in_ready` out 1: pair accepted on an edge where `in_valid && in_ready`.
- `div_a` out 64: registered dividend to the core.
- `div_b` out 64: registered divisor to the core.
- `div_z` in 64: quotient from the core.
- `out_z` out 64: quotient at FIFO head.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer pops on an edge where `out_valid && out_ready`.

## Operation
- Reset values: `div_a` = 0, `div_b` = 0, tag pipeline all 0, FIFO empty, `out_valid` = 0, `out_z` = 0, `inflight` = 0. `in_ready` is forced 0 while `rst_n` is low.
- **Accept:** on an accepting edge, `div_a` ← `in_a`, `div_b` ← `in_b`, and `tag[0]` ← 1. Otherwise `div_a`/`div_b` hold their value and `tag[0]` ← 0.
- **Tag pipeline:** `tag[k+1]` ← `tag[k]`, LATENCY+1 bits. `tag[LATENCY]` is high exactly in the cycle in which `div_z` carries a tagged result.
- **Capture:** on an edge with `tag[LATENCY]` = 1, `div_z` is pushed into the FIFO. Untagged `div_z` values are ignored.
- **Credit:** `in_ready` = (`inflight` + `fifo_count`) < DEPTH.
  - `inflight` increments on accept and decrements on push; both on the same edge leaves it unchanged.
  - `fifo_count` increments on push and decrements on pop.
  - The FIFO never overflows. An overflow is a design error and is flagged by a bench assertion.
- **Counter widths:** `inflight` and `fifo_count` are each $clog2(DEPTH+1) bits. FIFO pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- **Simultaneous push and pop:**
  - Legal at any occupancy, including full and empty-with-push.
  - Occupancy is unchanged.
  - If the FIFO is empty, the pushed value becomes visible on the following cycle; there is no bypass.
- **Ordering:** results emerge in acceptance order. The quotient value is passed through unaltered, including NaN, Inf and signed zero.
- **Reset mid-operation:** all in-flight tags and FIFO contents are discarded. Quotients still emerging from the core after reset are untagged and dropped.

## Timing
- Accept edge N: `div_a`/`div_b` are valid in cycle N+1. `div_z` carries the result in cycle N+1+LATENCY. The result is pushed at edge N+1+LATENCY. `out_valid` rises in cycle N+2+LATENCY.
- Minimum end-to-end latency: LATENCY+2 edges.
- Sustained throughput is 1 pair per cycle while `out_ready` = 1 and DEPTH ≥ LATENCY+2. Otherwise throughput is capped at DEPTH pairs per LATENCY+2 cycles.
- `in_ready` is combinational from registered counters only; it has no combinational dependence on `in_valid`.
- `out_valid` and `out_z` are driven from registers or FIFO storage only.
- Once `out_valid` is asserted, it and `out_z` stay stable until popped, except under reset.

## Structure
- Shared package `double_pkg`: `double_t` (64-bit), the constants `DOUBLE_NAN` = 64'h7FF8000000000000 and `DOUBLE_ZERO` = 64'h0, and a credit-width function.
- The natural sub-module is `result_fifo` (synchronous, DEPTH × 64, count output, async active-low reset).
- The tag pipeline and credit logic live in the top level.
- `double_div` is attached externally through the `div_*` ports.

## Test plan
- **Single op:** `in_a` = 64'h4018000000000000 (6.0), `in_b` = 64'h4000000000000000 (2.0), accepted at edge N. Required: `out_z` = 64'h4008000000000000 (3.0), with `out_valid` first high in cycle N+2+LATENCY.
- **Back-to-back stream:** 100 random pairs with `out_ready` = 1. Required: results match a golden model, in order, with `in_ready` never deasserting when DEPTH ≥ LATENCY+2.
- **Backpressure:** `out_ready` = 0 with 20 pairs offered. Required:
  - exactly DEPTH pairs are accepted, then `in_ready` = 0;
  - releasing `out_ready` drains DEPTH correct quotients;
  - no overflow assertion fires.
- **Full boundary:** at `fifo_count` = DEPTH, push and pop on the same edge. Required: occupancy stays at DEPTH and ordering is preserved.
- **Special values:** 1.0/0.0 gives 64'h7FF0000000000000. 0.0/0.0 gives NaN with exponent all ones and a non-zero mantissa.
- **Reset mid-flight:** assert `rst_n` low with 5 results in flight and 3 in the FIFO. Required:
  - `out_valid` = 0 immediately;
  - no stale result ever appears after release;
  - the next single op returns the correct quotient.
